control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch in T0-T2, then per-opcode execute steps, with a halt path.
// Optional feature: define ILLEGAL_TRAP_EN to halt and raise a sticky Illegal flag on unsupported opcodes.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        Rout,
    output logic        BAout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        Rin,
    output logic        CONin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  opcode,
    output logic        Run,
    output logic        Illegal
);

    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;
    localparam logic [4:0] ALU_ADD = 5'b00011;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    state_t state_reg;
    state_t state_next;
    state_t end_of_instr;

    logic [4:0] ir_op;
    logic       is_jal;
    logic       is_jr;
    logic       is_br;
    logic       is_nop;
    logic       is_halt;
    logic       is_supported;
    logic       ir_unused;

    // Only the opcode field steers sequencing; register fields go straight to the datapath.
    assign ir_op        = IR[31:27];
    assign ir_unused    = ^IR[26:0];
    assign is_jal       = (ir_op == OP_JAL);
    assign is_jr        = (ir_op == OP_JR);
    assign is_br        = (ir_op == OP_BR);
    assign is_nop       = (ir_op == OP_NOP);
    assign is_halt      = (ir_op == OP_HALT);
    assign is_supported = is_jal | is_jr | is_br | is_nop | is_halt;

    // Stop is only looked at on the edge that closes an instruction.
    assign end_of_instr = Stop ? S_HALTED : S_T0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == S_T3 && !is_supported) begin
            illegal_reg <= 1'b1;
        end
    end

    assign Illegal = illegal_reg;
`else
    assign Illegal = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RST: state_next = S_T0;
            S_T0:  state_next = S_T1;
            S_T1:  state_next = S_T2;
            S_T2:  state_next = S_T3;
            S_T3: begin
                if (is_halt) begin
                    state_next = S_HALTED;
                end else if (TRAP_EN && !is_supported) begin
                    state_next = S_HALTED;
                end else if (is_jal || is_br) begin
                    state_next = S_T4;
                end else begin
                    state_next = end_of_instr;
                end
            end
            S_T4:     state_next = is_br ? S_T5 : end_of_instr;
            S_T5:     state_next = S_T6;
            S_T6:     state_next = end_of_instr;
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_RST;
        endcase
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        ZLowIn  = 1'b0;
        Rin     = 1'b0;
        CONin   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        opcode  = 5'b00000;
        Run     = 1'b0;
        case (state_reg)
            S_T0: begin
                Run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_jal) begin
                    PCout = 1'b1;
                    Grb   = 1'b1;
                    Rin   = 1'b1;
                end else if (is_jr) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (is_br) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end
            end
            S_T4: begin
                Run = 1'b1;
                if (is_jal) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (is_br) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            S_T5: begin
                Run    = 1'b1;
                Cout   = 1'b1;
                ZLowIn = 1'b1;
                opcode = ALU_ADD;
            end
            S_T6: begin
                // Branch target already sits in Z; CON_FF decides whether it lands in PC.
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = CON_FF;
            end
            default: begin
                Run = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instructions then random ones against a table model.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
    logic        PCout, Zlowout, MDRout, Cout, Rout, BAout;
    logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin;
    logic        IncPC, Read, Write, Gra, Grb, Grc;
    logic [4:0]  opcode;
    logic        Run, Illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
        .Rin(Rin), .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .opcode(opcode), .Run(Run), .Illegal(Illegal)
    );

    always #5 clock = ~clock;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Observed control word: one bit per named output, ALU opcode in [6:2].
    localparam logic [26:0] B_ILL   = 27'd1 << 0;
    localparam logic [26:0] B_RUN   = 27'd1 << 1;
    localparam logic [26:0] B_ADD   = 27'd3 << 2;
    localparam logic [26:0] B_GRB   = 27'd1 << 8;
    localparam logic [26:0] B_GRA   = 27'd1 << 9;
    localparam logic [26:0] B_READ  = 27'd1 << 11;
    localparam logic [26:0] B_INCPC = 27'd1 << 12;
    localparam logic [26:0] B_CONIN = 27'd1 << 13;
    localparam logic [26:0] B_RIN   = 27'd1 << 14;
    localparam logic [26:0] B_ZLIN  = 27'd1 << 15;
    localparam logic [26:0] B_YIN   = 27'd1 << 16;
    localparam logic [26:0] B_IRIN  = 27'd1 << 17;
    localparam logic [26:0] B_MDRIN = 27'd1 << 18;
    localparam logic [26:0] B_PCIN  = 27'd1 << 19;
    localparam logic [26:0] B_MARIN = 27'd1 << 20;
    localparam logic [26:0] B_ROUT  = 27'd1 << 22;
    localparam logic [26:0] B_COUT  = 27'd1 << 23;
    localparam logic [26:0] B_MDROUT= 27'd1 << 24;
    localparam logic [26:0] B_ZLOUT = 27'd1 << 25;
    localparam logic [26:0] B_PCOUT = 27'd1 << 26;

    logic [26:0] obs_vec;
    assign obs_vec = {PCout, Zlowout, MDRout, Cout, Rout, BAout,
                      MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin, CONin,
                      IncPC, Read, Write, Gra, Grb, Grc, opcode, Run, Illegal};

    typedef enum int {K_JAL, K_JR, K_BR, K_NOP, K_HALT, K_ILL} kind_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_illegal = 1'b0;

    function automatic kind_t kind_of(logic [31:0] ir);
        case (ir[31:27])
            5'b10100: return K_JAL;
            5'b10011: return K_JR;
            5'b10010: return K_BR;
            5'b11001: return K_NOP;
            5'b11010: return K_HALT;
            default:  return K_ILL;
        endcase
    endfunction

    // Instruction length in cycles, fetch included.
    function automatic int length_of(kind_t k);
        case (k)
            K_JAL:   return 5;
            K_BR:    return 7;
            default: return 4;
        endcase
    endfunction

    function automatic logic [26:0] expect_step(kind_t k, int s, bit con);
        logic [26:0] e;
        e = B_RUN;
        case (s)
            0: e |= B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
            1: e |= B_ZLOUT | B_PCIN | B_READ | B_MDRIN;
            2: e |= B_MDROUT | B_IRIN;
            default: begin
                case (k)
                    K_JAL: e |= (s == 3) ? (B_PCOUT | B_GRB | B_RIN) : (B_GRA | B_ROUT | B_PCIN);
                    K_JR:  e |= B_GRA | B_ROUT | B_PCIN;
                    K_BR: begin
                        if (s == 3)      e |= B_GRA | B_ROUT | B_CONIN;
                        else if (s == 4) e |= B_PCOUT | B_YIN;
                        else if (s == 5) e |= B_COUT | B_ZLIN | B_ADD;
                        else             e |= B_ZLOUT | (con ? B_PCIN : 27'd0);
                    end
                    default: ;
                endcase
            end
        endcase
        return e;
    endfunction

    task automatic check(string tag, logic [26:0] exp);
        n_cmp++;
        assert (obs_vec === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs_vec, exp);
        end
        n_cmp++;
        assert ((Read & Write) === 1'b0) else begin
            n_bad++;
            $error("FAIL %s rw_excl: observed Read=%b Write=%b expected not both 1", tag, Read, Write);
        end
    endtask

    // Drops clear at the current time, holds it two cycles, then releases just after a rising edge.
    task automatic do_reset(string tag);
        clear = 1'b0;
        #1 check({tag, " async_rst"}, 27'd0);
        m_illegal = 1'b0;
        @(negedge clock);
        #1 check({tag, " rst_hold0"}, 27'd0);
        @(negedge clock);
        #1 check({tag, " rst_hold1"}, 27'd0);
        @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        #1 check({tag, " rst_state"}, 27'd0);
        $display("reset %s done", tag);
    endtask

    task automatic run_instr(logic [31:0] ir, bit con, bit stop, int abort_step, int idle, string tag);
        kind_t k = kind_of(ir);
        int    n = length_of(k);
        bit    halted;
        for (int s = 0; s < n; s++) begin
            @(negedge clock);
            IR     = (s < 3) ? $urandom : ir;
            CON_FF = (s == 6) ? con : 1'($urandom);
            Stop   = (s == n - 1) ? stop : 1'($urandom);
            #1 check($sformatf("%s step%0d", tag, s), expect_step(k, s, con));
            if (s == abort_step) begin
                $display("instr %s ir=%h aborted at step %0d", tag, ir, s);
                do_reset(tag);
                return;
            end
        end
        halted = (k == K_HALT) || stop || (TRAP && k == K_ILL);
        if (TRAP && k == K_ILL) m_illegal = 1'b1;
        $display("instr %s ir=%h con=%0b stop=%0b cycles=%0d halted=%0b", tag, ir, con, stop, n, halted);
        if (halted) begin
            for (int c = 0; c < idle; c++) begin
                @(negedge clock);
                IR     = $urandom;
                CON_FF = 1'($urandom);
                Stop   = 1'($urandom);
                #1 check($sformatf("%s halted%0d", tag, c), m_illegal ? B_ILL : 27'd0);
            end
            @(negedge clock);
            do_reset(tag);
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] rir;
        int          kk;
        clear  = 1'b1;
        IR     = 32'd0;
        CON_FF = 1'b0;
        Stop   = 1'b0;
        #2;
        do_reset("power_on");

        run_instr(32'hA2F80000, 1'b0, 1'b0, -1, 0,  "jal");
        run_instr(32'h91800000, 1'b1, 1'b0, -1, 0,  "br_taken");
        run_instr(32'h91800000, 1'b0, 1'b0, -1, 0,  "br_not_taken");
        run_instr(32'hC8000000, 1'b0, 1'b0, -1, 0,  "nop");
        run_instr(32'h9B800000, 1'b0, 1'b1, -1, 3,  "jr_stop");
        run_instr(32'hD0000000, 1'b0, 1'b0, -1, 20, "halt");
        run_instr(32'hF8000000, 1'b0, 1'b0, -1, 3,  "illegal");
        run_instr(32'hC8000000, 1'b0, 1'b0, -1, 0,  "after_illegal");
        run_instr(32'hA2F80000, 1'b0, 1'b0, 1,  0,  "rst_in_t1");
        run_instr(32'hA2F80000, 1'b0, 1'b0, -1, 0,  "jal_after_rst");

        for (int i = 0; i < 150; i++) begin
            kk = $urandom_range(0, 9);
            case (kk)
                0, 1:    op = 5'b10100;
                2, 3:    op = 5'b10011;
                4, 5, 6: op = 5'b10010;
                7:       op = 5'b11001;
                8:       op = 5'b11010;
                default: begin
                    op = 5'($urandom);
                    while (op == 5'b10100 || op == 5'b10011 || op == 5'b10010 ||
                           op == 5'b11001 || op == 5'b11010)
                        op = 5'($urandom);
                end
            endcase
            rir = {op, 27'($urandom)};
            run_instr(rir, 1'($urandom), ($urandom_range(0, 7) == 0), -1, 2,
                      $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
